lcg_vector_source: RTL
======================

Name: lcg_vector_source

Overview:
- Synthesizable upstream stimulus stage. Produces wide deterministic input vectors for the DUT's in_flat port using the team's 32-bit LCG: state = state*0x41C64E6D + 0x3039, modulo 2^32.
- Runs inside hardware harnesses, so vectors match the simulator benches bit for bit.
- Delivers each vector over a valid/ready handshake and counts the vectors it has sent.

Parameters:
- OUT_W, 136, vector width in bits; WORDS = ceil(OUT_W/32).
- SEED_DEFAULT, 107191021, LCG state loaded at reset.
- LCG_A, 32'h41C64E6D, multiplier.
- LCG_C, 32'h3039, increment.
- CNT_W, 32, width of vector count and request.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  pulse: load seed_in into the LCG state.
- seed_in  in  32  new seed.
- start  in  1  pulse: begin a run of num_vectors vectors.
- num_vectors  in  CNT_W  vectors per run; sampled on start.
- out_ready  in  1  consumer accepts the vector.
- out_data  out  OUT_W  current vector.
- out_valid  out  1  out_data holds a complete vector.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- vec_count  out  CNT_W  vectors accepted in the current or last run.

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE; LCG state = SEED_DEFAULT.
  - out_data = 0, out_valid = 0, busy = 0, done = 0, vec_count = 0.
- IDLE:
  - seed_load=1 → LCG state = seed_in on the next edge.
  - start=1 with num_vectors>0 → remaining = num_vectors, vec_count = 0, word index k = 0, busy = 1, go to FILL.
  - start=1 with num_vectors=0 → done pulses on the next cycle, state stays IDLE, vec_count = 0.
  - seed_load and start in the same cycle: the seed loads first, and the run uses the new seed.
- FILL:
  - Exactly one LCG step per cycle. The new state value is written to out_data[32k+31:32k]. The last word is truncated to OUT_W-32*(WORDS-1) bits (8 bits for 136), and its upper state bits are discarded.
  - After word WORDS-1, go to HOLD with out_valid=1. First out_valid occurs WORDS cycles after the start edge (5 for 136).
  - out_valid stays 0 throughout FILL; upper words are not cleared between vectors.
- HOLD:
  - out_data and out_valid stay stable until out_valid && out_ready.
  - On acceptance: vec_count += 1, remaining -= 1.
    - If remaining becomes 0: out_valid = 0, busy = 0, done pulses for one cycle, go to IDLE.
    - Otherwise: out_valid = 0, k = 0, go to FILL.
  - Steady-state throughput is one vector per WORDS+1 cycles.
- start and seed_load are ignored while busy=1.
- vec_count holds its final value in IDLE until the next start.
- LCG state persists across runs: a second run continues the sequence unless reseeded.
- Reset mid-run aborts immediately to reset values, with no done pulse.
- All arithmetic is modulo 2^32; the multiply keeps the low 32 bits only.

Optional Feature:
- Macro LCG_VECTOR_SOURCE_PREFETCH_EN.
- Defined:
  - A shadow buffer fills the next vector during HOLD.
  - On acceptance, the shadow moves to out_data in the same edge, and out_valid stays 1 when remaining>1.
  - With out_ready held high, throughput is one vector per WORDS cycles.
  - The LCG sequence and vector contents are identical to the undefined build.
  - The prefetch never advances the LCG beyond the final vector of the run.
- Undefined: the single-buffer behaviour described above.

Test Plan:
- Seed 0 via seed_load, start with num_vectors=1, out_ready=1:
  - word0 = 32'h00003039, word1 = 32'hD3DC167E.
  - out_valid rises 5 cycles after start; done pulses once; vec_count = 1.
- Reset only, num_vectors=3: the three vectors equal bench words from seed 107191021 (LCG steps 1-5, 6-10, 11-15); bits [135:128] equal the low byte of steps 5, 10 and 15.
- Backpressure, out_ready=0 for 10 cycles in HOLD: out_data stable and out_valid=1 throughout; after release, vec_count increments exactly once.
- num_vectors=0 start: no out_valid; done pulses one cycle later; busy stays 0.
- start and seed_load pulsed mid-run: no effect on data or count. Async rst asserted mid-FILL: all outputs zero within the same cycle, and the next run restarts from SEED_DEFAULT.
- Two back-to-back runs of 2 vectors each: the second run's first vector equals step-11..15 data, i.e. the sequence continues. With PREFETCH_EN and out_ready=1, acceptances occur every 5 cycles.

Source files
------------

// File: rtl/lcg_vector_source.sv
// rtl/lcg_vector_source.sv - LCG-driven wide vector source with valid/ready delivery and run counting
// Define LCG_VECTOR_SOURCE_PREFETCH_EN to fill the next vector into a shadow buffer while holding.
module lcg_vector_source #(
    parameter int          OUT_W        = 136,
    parameter logic [31:0] SEED_DEFAULT = 32'd107191021,
    parameter logic [31:0] LCG_A        = 32'h41C64E6D,
    parameter logic [31:0] LCG_C        = 32'h3039,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count
);
    localparam int WORDS = (OUT_W + 31) / 32;
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      lcg_q, lcg_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] fetch_left_q, fetch_left_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef LCG_VECTOR_SOURCE_PREFETCH_EN
    logic [OUT_W-1:0] shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
`endif

    logic [31:0]      lcg_next;
    logic             accept;
    logic             can_fill;
    logic [OUT_W-1:0] fill_buf;

    assign lcg_next = lcg_q * LCG_A + LCG_C;
    assign accept   = out_valid_q && out_ready;

    // fetch_left counts vectors still to be generated, so the LCG never runs past the run's last vector
`ifdef LCG_VECTOR_SOURCE_PREFETCH_EN
    assign can_fill = busy_q && (fetch_left_q != '0) && !shadow_full_q;
`else
    assign can_fill = busy_q && (fetch_left_q != '0) && (state_q == S_FILL);
`endif

    always_comb begin
        state_d      = state_q;
        lcg_d        = lcg_q;
        k_d          = k_q;
        remaining_d  = remaining_q;
        fetch_left_d = fetch_left_q;
        vec_count_d  = vec_count_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef LCG_VECTOR_SOURCE_PREFETCH_EN
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        fill_buf      = shadow_q;
`else
        fill_buf      = out_data_q;
`endif

        if (state_q == S_IDLE) begin
            if (seed_load) begin
                lcg_d = seed_in;
            end
            if (start) begin
                vec_count_d = '0;
                if (num_vectors == '0) begin
                    done_d = 1'b1;
                end else begin
                    remaining_d  = num_vectors;
                    fetch_left_d = num_vectors;
                    k_d          = '0;
                    busy_d       = 1'b1;
                    state_d      = S_FILL;
                end
            end
        end else begin
            if (accept) begin
                vec_count_d = vec_count_q + CNT_W'(1);
                remaining_d = remaining_q - CNT_W'(1);
                out_valid_d = 1'b0;
                state_d     = S_FILL;
                if (remaining_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef LCG_VECTOR_SOURCE_PREFETCH_EN
                else if (shadow_full_q) begin
                    out_data_d    = shadow_q;
                    out_valid_d   = 1'b1;
                    shadow_full_d = 1'b0;
                    state_d       = S_HOLD;
                end
`endif
            end

            if (can_fill) begin
                lcg_d = lcg_next;
                for (int i = 0; i < OUT_W; i++) begin
                    if (k_q == KW'(i / 32)) begin
                        fill_buf[i] = lcg_next[i % 32];
                    end
                end
`ifdef LCG_VECTOR_SOURCE_PREFETCH_EN
                shadow_d = fill_buf;
`else
                out_data_d = fill_buf;
`endif
                if (k_q == KW'(WORDS - 1)) begin
                    k_d          = '0;
                    fetch_left_d = fetch_left_q - CNT_W'(1);
`ifdef LCG_VECTOR_SOURCE_PREFETCH_EN
                    // A finished vector goes straight out if the output slot is free this edge
                    if (state_q == S_FILL || accept) begin
                        out_data_d  = fill_buf;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        shadow_full_d = 1'b1;
                    end
`else
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
`endif
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lcg_q        <= SEED_DEFAULT;
            k_q          <= '0;
            remaining_q  <= '0;
            fetch_left_q <= '0;
            vec_count_q  <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LCG_VECTOR_SOURCE_PREFETCH_EN
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lcg_q        <= lcg_d;
            k_q          <= k_d;
            remaining_q  <= remaining_d;
            fetch_left_q <= fetch_left_d;
            vec_count_q  <= vec_count_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef LCG_VECTOR_SOURCE_PREFETCH_EN
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_count = vec_count_q;
endmodule
